io_input_conditioner: RTL and testbench
=======================================

# io_input_conditioner

Synchronizes, debounces and edge-detects the board switch and push-button inputs before they reach the core's `i_io_sw` / `i_io_btn` ports. It sits between the FPGA pins and the single-cycle core. The core therefore only ever sees clean, metastability-free, single-transition levels. It also provides one-cycle press pulses for polled or interrupt-style use.

## Interface
- `SW_W`, default 32: switch width.
- `BTN_W`, default 4: button width.
- `TICK_DIV`, default 50000: clock cycles per debounce sample tick. Must be ≥ 2.
- `SAMPLES`, default 4: consecutive disagreeing ticks needed to accept a change. Must be ≥ 1.
- `BTN_ACTIVE_LOW`, default 1: when 1, raw buttons are inverted at the input, so a pressed button reads as 1 internally.
- `i_clk`, input, 1: system clock, shared with the core.
- `i_rst`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `i_sw_raw`, input, `SW_W`: raw switch pins, asynchronous.
- `i_btn_raw`, input, `BTN_W`: raw button pins, asynchronous.
- `o_io_sw`, output, `SW_W`: debounced switch levels. Connects to core `i_io_sw`.
- `o_io_btn`, output, `BTN_W`: debounced button levels, 1 = pressed. Connects to core `i_io_btn`.
- `o_btn_press`, output, `BTN_W`: one-cycle pulse per button on a debounced 0→1 transition.
- `o_btn_release`, output, `BTN_W`: one-cycle pulse per button on a debounced 1→0 transition.
- `o_tick`, output, 1: sample-tick strobe, exported for debug.

## Operation
- **Input polarity.** Buttons are XORed with `BTN_ACTIVE_LOW` before synchronization. Switches are used unmodified.
- **Synchronizer.** Each input bit passes through a 2-flop synchronizer. Both flops reset to 0, the logical released / off value.
- **Prescaler.**
  - Counter `tick_cnt` runs 0..`TICK_DIV`-1 and wraps to 0.
  - `o_tick` is 1 during exactly the cycle in which `tick_cnt` == `TICK_DIV`-1.
- **Per-bit debounce.** Each bit keeps a stable value `stab` and a counter `cnt`. The counter is `$clog2(SAMPLES+1)` bits wide and saturates at `SAMPLES`. On each cycle with `o_tick` = 1:
  - synced == `stab`: clear `cnt` to 0.
  - synced != `stab` and `cnt` == `SAMPLES`-1: set `stab` to synced and clear `cnt` to 0 (accept the change).
  - synced != `stab` otherwise: increment `cnt`.
  - Non-tick cycles hold all state.
- **Glitch rejection.** A glitch shorter than `SAMPLES` consecutive ticks never changes `stab`. Any agreeing tick restarts the count from 0.
- **Outputs.**
  - `o_io_sw` = `stab` of the switch bits.
  - `o_io_btn` = `stab` of the button bits.
- **Edge pulses.**
  - `o_btn_press[i]` = 1 on the cycle after `stab` of button i goes 0→1.
  - `o_btn_release[i]` = 1 on the cycle after it goes 1→0.
  - Pulses are exactly one cycle wide. They are generated by comparing `stab` with its value delayed by one cycle.
- **Independence.** All bits are independent. Simultaneous changes on several bits are each accepted on their own qualifying tick.

## Timing
- **Reset values** while `i_rst` = 1, asynchronously:
  - `o_io_sw` = 0, `o_io_btn` = 0.
  - `o_btn_press` = 0, `o_btn_release` = 0.
  - `o_tick` = 0, `tick_cnt` = 0.
  - All synchronizer flops, `stab` and `cnt` = 0.
- **First tick after reset.** The first `o_tick` occurs `TICK_DIV` cycles after the first rising edge with `i_rst` = 0.
- **Level latency.** A clean raw step at cycle t reaches the synced value at edge t+2. `o_io_*` changes on the `SAMPLES`-th tick at or after t+2. Latency therefore lies in [2+(`SAMPLES`-1)·`TICK_DIV`+1, 2+`SAMPLES`·`TICK_DIV`] cycles.
- **Pulse timing.** `o_btn_press` / `o_btn_release` assert exactly 1 cycle after the corresponding `o_io_btn` transition.
- **Reset mid-debounce.** All progress is discarded. After reset release, a held input must qualify again from `cnt` = 0, and no pulse is emitted during reset.
- **Input held through reset.** A button held pressed through reset is seen as a new 0→1 edge once debounced after reset, and it produces a press pulse.
- **Register boundary.** No combinational path exists from raw inputs to any output.

## Test plan
Bench parameters: `TICK_DIV`=4, `SAMPLES`=3, `BTN_ACTIVE_LOW`=1.
- **Reset.** Hold `i_rst` = 1 with `i_btn_raw` = 4'b0000 (all pressed). All outputs must be 0. After release, `o_io_btn` goes to 4'b1111 within 2+12 cycles, and `o_btn_press` pulses 4'b1111 for exactly 1 cycle, 1 cycle later.
- **Clean press.** Drive `i_btn_raw[0]` 1→0 and hold. `o_io_btn[0]` rises within [11, 14] cycles. Exactly one `o_btn_press[0]` pulse follows. Releasing gives exactly one `o_btn_release[0]` pulse.
- **Glitch rejection.** Pulse `i_sw_raw[5]` to 1 for 6 cycles, then back to 0. `o_io_sw` must stay 32'h0 for 100 cycles.
- **Bounce.** Toggle `i_btn_raw[2]` every 3 cycles for 30 cycles, then hold 0. `o_io_btn[2]` must make exactly one 0→1 transition, with exactly one press pulse and no release pulse.
- **Reset mid-debounce.** Set `i_sw_raw` = 32'hA5A5_0000. Assert `i_rst` for 1 cycle after 2 ticks. `o_io_sw` must stay 0 and then reach 32'hA5A5_0000 no sooner than 11 cycles after reset release.
- **Prescaler.** Check that `o_tick` has a period of exactly 4 cycles and a width of exactly 1 cycle over 40 cycles.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Pin-side conditioner for switches and buttons: 2-flop synchronizer, tick-sampled
// counting debouncer, and registered one-cycle press/release pulses for the buttons.
module io_input_conditioner #(
  parameter int SW_W           = 32,
  parameter int BTN_W          = 4,
  parameter int TICK_DIV       = 50000,
  parameter int SAMPLES        = 4,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SW_W-1:0]  i_sw_raw,
  input  logic [BTN_W-1:0] i_btn_raw,
  output logic [SW_W-1:0]  o_io_sw,
  output logic [BTN_W-1:0] o_io_btn,
  output logic [BTN_W-1:0] o_btn_press,
  output logic [BTN_W-1:0] o_btn_release,
  output logic             o_tick
);

  localparam int N   = SW_W + BTN_W;
  localparam int TCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int CW  = (SAMPLES > 1) ? $clog2(SAMPLES + 1) : 1;

  localparam logic [TCW-1:0]   TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [TCW-1:0]   TICK_PRE  = TCW'(TICK_DIV - 2);
  localparam logic [TCW-1:0]   TICK_ONE  = TCW'(1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(SAMPLES - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [BTN_W-1:0] BTN_POL   = (BTN_ACTIVE_LOW != 0) ? {BTN_W{1'b1}} : {BTN_W{1'b0}};

  logic [N-1:0]     w_raw;
  logic [N-1:0]     w_stab;
  logic [N-1:0]     r_sync1;
  logic [N-1:0]     r_sync2;
  logic [TCW-1:0]   r_tick_cnt;
  logic             r_tick;
  logic [BTN_W-1:0] r_btn_d;
  logic [BTN_W-1:0] r_press;
  logic [BTN_W-1:0] r_release;

  // Buttons are inverted up front so every internal bit uses 1 = active.
  assign w_raw = {i_btn_raw ^ BTN_POL, i_sw_raw};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= {N{1'b0}};
      r_sync2 <= {N{1'b0}};
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // r_tick is registered from the pre-terminal count so it is high exactly while the count sits at TICK_DIV-1.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tick_cnt <= {TCW{1'b0}};
      r_tick     <= 1'b0;
    end else begin
      if (r_tick_cnt == TICK_LAST) begin
        r_tick_cnt <= {TCW{1'b0}};
      end else begin
        r_tick_cnt <= r_tick_cnt + TICK_ONE;
      end
      r_tick <= (r_tick_cnt == TICK_PRE);
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_db
    logic          r_stab;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_stab <= 1'b0;
        r_cnt  <= {CW{1'b0}};
      end else if (r_tick) begin
        if (r_sync2[g] == r_stab) begin
          r_cnt <= {CW{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
          r_stab <= r_sync2[g];
          r_cnt  <= {CW{1'b0}};
        end else begin
          r_cnt <= r_cnt + CNT_ONE;
        end
      end
    end

    assign w_stab[g] = r_stab;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_btn_d   <= {BTN_W{1'b0}};
      r_press   <= {BTN_W{1'b0}};
      r_release <= {BTN_W{1'b0}};
    end else begin
      r_btn_d   <= w_stab[N-1:SW_W];
      r_press   <= w_stab[N-1:SW_W] & ~r_btn_d;
      r_release <= ~w_stab[N-1:SW_W] & r_btn_d;
    end
  end

  assign o_io_sw       = w_stab[SW_W-1:0];
  assign o_io_btn      = w_stab[N-1:SW_W];
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;
  assign o_tick        = r_tick;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Scoreboard bench for io_input_conditioner: stimulus queues expected output snapshots
// with cycle windows, a negedge monitor pops one per observed output change.
module tb_io_input_conditioner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sw_raw = 32'h0;
  logic [3:0]  btn_raw = 4'h0;
  logic [31:0] o_io_sw;
  logic [3:0]  o_io_btn;
  logic [3:0]  o_btn_press;
  logic [3:0]  o_btn_release;
  logic        o_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_ev = 0;

  typedef struct {
    string       name;
    logic [43:0] snap;
    int          lo;
    int          hi;
    bit          rel;
  } exp_t;

  exp_t        sbq[$];
  logic [43:0] prev_snap = 44'h0;

  io_input_conditioner #(
    .SW_W(32), .BTN_W(4), .TICK_DIV(4), .SAMPLES(3), .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
    .o_io_sw(o_io_sw), .o_io_btn(o_io_btn), .o_btn_press(o_btn_press),
    .o_btn_release(o_btn_release), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output snapshot must match the next queued expectation.
  always @(negedge clk) begin
    logic [43:0] snap;
    exp_t        e;
    int          when;
    snap = {o_io_sw, o_io_btn, o_btn_press, o_btn_release};
    if (snap !== prev_snap) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event cyc=%0d got=%h", cyc, snap);
      end else begin
        e = sbq.pop_front();
        when = e.rel ? (cyc - last_ev) : cyc;
        if (snap !== e.snap || when < e.lo || when > e.hi)
          begin
            n_fail++;
            $display("FAIL %s got=%h at %0d, expected=%h in [%0d,%0d]",
                     e.name, snap, when, e.snap, e.lo, e.hi);
          end
      end
      last_ev   = cyc;
      prev_snap = snap;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input string nm, input logic [31:0] s, input logic [3:0] b,
                      input logic [3:0] p, input logic [3:0] r,
                      input int lo, input int hi, input bit rel);
    exp_t e;
    e.name = nm;
    e.snap = {s, b, p, r};
    e.lo   = lo;
    e.hi   = hi;
    e.rel  = rel;
    sbq.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [43:0] got, input logic [43:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic drain(input string nm, input int maxc);
    int k;
    k = 0;
    while (sbq.size() != 0 && k < maxc) begin
      step(1);
      k++;
    end
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s pending=%0d expected=0", nm, sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t, c0, kb, nt, k, last_rise, highs;
    logic prev_tick;

    // Reset with all buttons held pressed (active-low pins at 0).
    step(5);
    chk("reset_outputs", {o_io_sw, o_io_btn, o_btn_press, o_btn_release}, 44'h0);
    chk("reset_tick", {43'h0, o_tick}, 44'h0);
    c0 = cyc;
    push("rst_btn",       32'h0, 4'hF, 4'h0, 4'h0, c0 + 11, c0 + 14, 1'b0);
    push("rst_press",     32'h0, 4'hF, 4'hF, 4'h0, 1, 1, 1'b1);
    push("rst_press_end", 32'h0, 4'hF, 4'h0, 4'h0, 1, 1, 1'b1);
    rst = 1'b0;
    drain("rst_drain", 40);
    chk("rst_btn_level", {40'h0, o_io_btn}, 44'hF);

    // Release all buttons.
    step(1);
    t = cyc;
    btn_raw = 4'hF;
    push("relall_btn",   32'h0, 4'h0, 4'h0, 4'h0, t + 11, t + 14, 1'b0);
    push("relall_pulse", 32'h0, 4'h0, 4'h0, 4'hF, 1, 1, 1'b1);
    push("relall_end",   32'h0, 4'h0, 4'h0, 4'h0, 1, 1, 1'b1);
    drain("relall_drain", 40);

    // Clean press and release of button 0.
    step(3);
    t = cyc;
    btn_raw = 4'b1110;
    push("press0_btn",   32'h0, 4'h1, 4'h0, 4'h0, t + 11, t + 14, 1'b0);
    push("press0_pulse", 32'h0, 4'h1, 4'h1, 4'h0, 1, 1, 1'b1);
    push("press0_end",   32'h0, 4'h1, 4'h0, 4'h0, 1, 1, 1'b1);
    drain("press0_drain", 40);
    step(5);
    t = cyc;
    btn_raw = 4'hF;
    push("rel0_btn",   32'h0, 4'h0, 4'h0, 4'h0, t + 11, t + 14, 1'b0);
    push("rel0_pulse", 32'h0, 4'h0, 4'h0, 4'h1, 1, 1, 1'b1);
    push("rel0_end",   32'h0, 4'h0, 4'h0, 4'h0, 1, 1, 1'b1);
    drain("rel0_drain", 40);

    // Six-cycle glitch on switch 5 must be rejected.
    step(1);
    sw_raw[5] = 1'b1;
    step(6);
    sw_raw[5] = 1'b0;
    step(100);
    chk("glitch_sw", {12'h0, o_io_sw}, 44'h0);

    // Bounce on button 2, then settle pressed.
    step(1);
    kb = cyc;
    push("bounce_btn",   32'h0, 4'h4, 4'h0, 4'h0, kb + 1, kb + 30 + 14, 1'b0);
    push("bounce_press", 32'h0, 4'h4, 4'h4, 4'h0, 1, 1, 1'b1);
    push("bounce_end",   32'h0, 4'h4, 4'h0, 4'h0, 1, 1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      btn_raw[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(3);
    end
    btn_raw[2] = 1'b0;
    drain("bounce_drain", 60);
    step(40);
    chk("bounce_level", {40'h0, o_io_btn}, 44'h4);
    t = cyc;
    btn_raw = 4'hF;
    push("rel2_btn",   32'h0, 4'h0, 4'h0, 4'h0, t + 11, t + 14, 1'b0);
    push("rel2_pulse", 32'h0, 4'h0, 4'h0, 4'h4, 1, 1, 1'b1);
    push("rel2_end",   32'h0, 4'h0, 4'h0, 4'h0, 1, 1, 1'b1);
    drain("rel2_drain", 40);

    // Reset in the middle of debouncing a switch pattern.
    step(1);
    sw_raw = 32'hA5A5_0000;
    nt = 0;
    k  = 0;
    while (nt < 2 && k < 20) begin
      @(negedge clk);
      if (o_tick) nt++;
      k++;
    end
    chk("mid_two_ticks", 44'(nt), 44'd2);
    step(1);
    rst = 1'b1;
    step(1);
    chk("mid_sw_in_reset", {12'h0, o_io_sw}, 44'h0);
    c0 = cyc;
    push("mid_sw", 32'hA5A5_0000, 4'h0, 4'h0, 4'h0, c0 + 11, c0 + 14, 1'b0);
    rst = 1'b0;
    drain("mid_drain", 40);

    // Prescaler period and width over 40 cycles.
    prev_tick = 1'b0;
    last_rise = -1;
    highs     = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_tick) begin
        highs++;
        chk("tick_width", {43'h0, prev_tick}, 44'h0);
        if (!prev_tick && last_rise >= 0) chk("tick_period", 44'(cyc - last_rise), 44'd4);
        if (!prev_tick) last_rise = cyc;
      end
      prev_tick = o_tick;
    end
    chk("tick_count", 44'(highs), 44'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
